// File: rtl/imm_pkg.sv
// Shared types, opcodes and the immediate extraction function for the
// pipelined RISC-V immediate generator.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_Z    = 3'd5,
        IMM_SH   = 3'd6,
        IMM_NONE = 3'd7
    } imm_src_e;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // SH returns the 6-bit RV64 shamt; RV32 callers must clear bit 5.
    function automatic logic [63:0] imm_extract(input logic [31:0] instr, input imm_src_e src);
        logic [63:0] imm;
        case (src)
            IMM_I:   imm = {{52{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {{32{instr[31]}}, instr[31:12], 12'b0};
            IMM_J:   imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_Z:   imm = {59'b0, instr[19:15]};
            IMM_SH:  imm = {58'b0, instr[25:20]};
            default: imm = 64'b0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// Two-entry skid buffer: registered output plus one overflow slot, with
// in_ready coming straight from a flop so it never depends on out_ready.
module imm_skid_buf
    import imm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_e  state_q, state_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         in_ready_q, in_ready_d;
    logic         accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SKID_EMPTY;
            out_data_q  <= '0;
            skid_data_q <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= in_ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        skid_data_d = skid_data_q;
        accept      = in_valid && in_ready_q;
        case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    out_data_d = in_data;
                    state_d    = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (accept && out_ready) begin
                    out_data_d = in_data;
                end else if (accept) begin
                    skid_data_d = in_data;
                    state_d     = SKID_TWO;
                end else if (out_ready) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                // in_ready is low here, so only a drain can happen
                if (out_ready) begin
                    out_data_d = skid_data_q;
                    state_d    = SKID_ONE;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
        in_ready_d = (state_d != SKID_TWO);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != SKID_EMPTY);
    assign out_data  = out_data_q;

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: combinational format decode and
// extraction, registered through a skid buffer with valid/ready handshakes.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TAG_W       = 32,
    parameter bit AUTO_DECODE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam int PW = XLEN + TAG_W + 1;

    imm_src_e        src;
    logic            illegal;
    logic [XLEN-1:0] imm;
    logic [PW-1:0]   pay_in;
    logic [PW-1:0]   pay_out;

    always_comb begin
        logic [63:0] full;
        src     = imm_src_e'(in_imm_src);
        illegal = 1'b0;
        if (AUTO_DECODE) begin
            case (in_instr[6:0])
                OP_LOAD, OP_JALR:  src = IMM_I;
                OP_IMM:            src = (in_instr[13:12] == 2'b01) ? IMM_SH : IMM_I;
                OP_STORE:          src = IMM_S;
                OP_BRANCH:         src = IMM_B;
                OP_LUI, OP_AUIPC:  src = IMM_U;
                OP_JAL:            src = IMM_J;
                OP_SYSTEM:         src = in_instr[14] ? IMM_Z : IMM_I;
                default: begin
                    src     = IMM_NONE;
                    illegal = 1'b1;
                end
            endcase
        end
        full = imm_extract(in_instr, src);
        // RV32 shift amounts are only 5 bits wide
        if (src == IMM_SH && XLEN == 32) begin
            full[5] = 1'b0;
        end
        imm = full[XLEN-1:0];
    end

    assign pay_in = {illegal, in_tag, imm};

    imm_skid_buf #(
        .W(PW)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (pay_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (pay_out)
    );

    assign out_imm     = pay_out[XLEN-1:0];
    assign out_tag     = pay_out[XLEN +: TAG_W];
    assign out_illegal = pay_out[PW-1];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe: manual RV32, manual RV64
// and auto-decode instances sharing one clock and reset.
module tb_imm_gen_pipe;
    import imm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // instance A: XLEN=32 manual
    logic        a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0, a_out_illegal;
    logic [31:0] a_in_instr = 0, a_in_tag = 0, a_out_imm, a_out_tag;
    logic [2:0]  a_in_imm_src = 0;
    // instance B: XLEN=64 manual
    logic        b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0, b_out_illegal;
    logic [31:0] b_in_instr = 0, b_in_tag = 0, b_out_tag;
    logic [63:0] b_out_imm;
    logic [2:0]  b_in_imm_src = 0;
    // instance C: XLEN=32 auto-decode
    logic        c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0, c_out_illegal;
    logic [31:0] c_in_instr = 0, c_in_tag = 0, c_out_imm, c_out_tag;
    logic [2:0]  c_in_imm_src = 0;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .AUTO_DECODE(1'b0)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_instr(a_in_instr), .in_imm_src(a_in_imm_src), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_imm(a_out_imm),
        .out_tag(a_out_tag), .out_illegal(a_out_illegal));

    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .AUTO_DECODE(1'b0)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_instr(b_in_instr), .in_imm_src(b_in_imm_src), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm),
        .out_tag(b_out_tag), .out_illegal(b_out_illegal));

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .AUTO_DECODE(1'b1)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_instr(c_in_instr), .in_imm_src(c_in_imm_src), .in_tag(c_in_tag),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_imm(c_out_imm),
        .out_tag(c_out_tag), .out_illegal(c_out_illegal));

    localparam logic [31:0] V_INSTR [5] = '{32'hFFF12383, 32'h00F12323, 32'hFE512EE3, 32'h12345037, 32'hFFF0016F};
    localparam logic [2:0]  V_SRC   [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    localparam logic [31:0] V_EXP   [5] = '{32'hFFFFFFFF, 32'h00000006, 32'hFFFFFFFC, 32'h12345000, 32'hFFF00FFE};

    localparam logic [31:0] AU_INSTR [4] = '{32'h30529073, 32'h3052D073, 32'h4030D093, 32'h00000033};
    localparam logic [31:0] AU_EXP   [4] = '{32'h00000305, 32'h00000005, 32'h00000003, 32'h00000000};
    localparam logic        AU_ILL   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    task automatic test_reset();
        a_in_valid = 1'b1;
        a_in_instr = 32'h12345037;
        a_in_imm_src = IMM_U;
        a_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0 || a_out_imm !== 32'h0 || a_out_tag !== 32'h0 || a_out_illegal !== 1'b0)
            begin errors++; $display("FAIL reset_a: valid=%b imm=%h tag=%h ill=%b, required 0/0/0/0", a_out_valid, a_out_imm, a_out_tag, a_out_illegal); end
        checks++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1 || c_in_ready !== 1'b1)
            begin errors++; $display("FAIL reset_in_ready: a=%b b=%b c=%b, required 1", a_in_ready, b_in_ready, c_in_ready); end
        checks++;
        if (b_out_valid !== 1'b0 || b_out_imm !== 64'h0 || c_out_valid !== 1'b0 || c_out_illegal !== 1'b0)
            begin errors++; $display("FAIL reset_bc: bvalid=%b bimm=%h cvalid=%b cill=%b, required zeros", b_out_valid, b_out_imm, c_out_valid, c_out_illegal); end
        a_in_valid = 1'b0;
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_manual_b2b();
        a_out_ready = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (a_out_valid !== 1'b1 || a_out_imm !== V_EXP[i-1] || a_out_tag !== 32'h100 + i - 1)
                    begin errors++; $display("FAIL b2b_%0d: valid=%b imm=%h tag=%h, required 1 %h %h", i-1, a_out_valid, a_out_imm, a_out_tag, V_EXP[i-1], 32'h100 + i - 1); end
                else $display("b2b %0d: instr=%h imm=%h tag=%h", i-1, V_INSTR[i-1], a_out_imm, a_out_tag);
            end
            if (i < 5) begin
                checks++;
                if (a_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_%0d: got %b required 1", i, a_in_ready); end
                a_in_valid = 1'b1;
                a_in_instr = V_INSTR[i];
                a_in_imm_src = V_SRC[i];
                a_in_tag = 32'h100 + i;
            end else begin
                a_in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_xlen();
        b_out_ready = 1'b1;
        a_out_ready = 1'b1;
        @(negedge clk);
        b_in_valid = 1'b1; b_in_instr = 32'h80000037; b_in_imm_src = IMM_U;  b_in_tag = 32'h11;
        a_in_valid = 1'b1; a_in_instr = 32'h03F01013; a_in_imm_src = IMM_SH; a_in_tag = 32'h12;
        @(negedge clk);
        checks++;
        if (b_out_valid !== 1'b1 || b_out_imm !== 64'hFFFFFFFF80000000 || b_out_tag !== 32'h11)
            begin errors++; $display("FAIL x64_u: valid=%b imm=%h tag=%h, required 1 ffffffff80000000 11", b_out_valid, b_out_imm, b_out_tag); end
        else $display("x64 U: imm=%h", b_out_imm);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_imm !== 32'h0000001F)
            begin errors++; $display("FAIL x32_sh: valid=%b imm=%h, required 1 0000001f", a_out_valid, a_out_imm); end
        else $display("x32 SH: imm=%h", a_out_imm);
        b_in_instr = 32'h03F01013; b_in_imm_src = IMM_SH; b_in_tag = 32'h13;
        a_in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (b_out_valid !== 1'b1 || b_out_imm !== 64'h000000000000003F || b_out_tag !== 32'h13)
            begin errors++; $display("FAIL x64_sh: valid=%b imm=%h tag=%h, required 1 000000000000003f 13", b_out_valid, b_out_imm, b_out_tag); end
        else $display("x64 SH: imm=%h", b_out_imm);
        b_in_valid = 1'b0;
    endtask

    task automatic test_auto();
        c_out_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (c_out_valid !== 1'b1 || c_out_imm !== AU_EXP[i-1] || c_out_illegal !== AU_ILL[i-1] || c_out_tag !== 32'h50 + i - 1)
                    begin errors++; $display("FAIL auto_%0d: valid=%b imm=%h ill=%b tag=%h, required 1 %h %b %h", i-1, c_out_valid, c_out_imm, c_out_illegal, c_out_tag, AU_EXP[i-1], AU_ILL[i-1], 32'h50 + i - 1); end
                else $display("auto %0d: instr=%h imm=%h illegal=%b", i-1, AU_INSTR[i-1], c_out_imm, c_out_illegal);
            end
            if (i < 4) begin
                c_in_valid = 1'b1;
                c_in_instr = AU_INSTR[i];
                c_in_imm_src = IMM_J;   // must be ignored in auto mode
                c_in_tag = 32'h50 + i;
            end else begin
                c_in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_back_pressure();
        int sent = 0;
        int recv = 0;
        logic stall_prev = 1'b0;
        logic [31:0] saved_imm = '0;
        logic [31:0] saved_tag = '0;
        a_out_ready = 1'b0;
        for (int c = 0; c < 30 && recv < 4; c++) begin
            @(negedge clk);
            if (stall_prev) begin
                checks++;
                if (a_out_valid !== 1'b1 || a_out_imm !== saved_imm || a_out_tag !== saved_tag)
                    begin errors++; $display("FAIL bp_stable_c%0d: valid=%b imm=%h tag=%h, required 1 %h %h", c, a_out_valid, a_out_imm, a_out_tag, saved_imm, saved_tag); end
            end
            if (c == 2) begin
                checks++;
                if (a_in_ready !== 1'b0 || sent != 2)
                    begin errors++; $display("FAIL bp_full: in_ready=%b accepts=%0d, required 0 and 2", a_in_ready, sent); end
            end
            a_out_ready = (c >= 3);
            a_in_valid = (sent < 4);
            if (sent < 4) begin
                a_in_instr = V_INSTR[sent];
                a_in_imm_src = V_SRC[sent];
                a_in_tag = 32'h200 + sent;
            end
            if (a_out_valid && a_out_ready) begin
                checks++;
                if (a_out_imm !== V_EXP[recv] || a_out_tag !== 32'h200 + recv)
                    begin errors++; $display("FAIL bp_order_%0d: imm=%h tag=%h, required %h %h", recv, a_out_imm, a_out_tag, V_EXP[recv], 32'h200 + recv); end
                else $display("bp recv %0d: imm=%h tag=%h", recv, a_out_imm, a_out_tag);
                recv++;
            end
            if (a_in_valid && a_in_ready) sent++;
            stall_prev = a_out_valid && !a_out_ready;
            saved_imm = a_out_imm;
            saved_tag = a_out_tag;
        end
        checks++;
        if (recv != 4) begin errors++; $display("FAIL bp_timeout: received %0d, required 4", recv); end
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: out_valid=%b required 0", a_out_valid); end
    endtask

    task automatic test_reset_mid();
        a_out_ready = 1'b0;
        @(negedge clk);
        a_in_valid = 1'b1; a_in_instr = V_INSTR[0]; a_in_imm_src = V_SRC[0]; a_in_tag = 32'h30;
        @(negedge clk);
        a_in_instr = V_INSTR[1]; a_in_imm_src = V_SRC[1]; a_in_tag = 32'h31;
        @(negedge clk);
        checks++;
        if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1)
            begin errors++; $display("FAIL rm_two: in_ready=%b out_valid=%b, required 0 1", a_in_ready, a_out_valid); end
        a_in_instr = V_INSTR[2]; a_in_imm_src = V_SRC[2]; a_in_tag = 32'h32;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_out_imm !== 32'h0 || a_out_tag !== 32'h0 || a_out_illegal !== 1'b0 || a_in_ready !== 1'b1)
            begin errors++; $display("FAIL rm_async: valid=%b imm=%h tag=%h ill=%b in_ready=%b, required 0 0 0 0 1", a_out_valid, a_out_imm, a_out_tag, a_out_illegal, a_in_ready); end
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rm_ignored: out_valid=%b required 0", a_out_valid); end
        rst = 1'b0;
        a_out_ready = 1'b1;
        a_in_instr = V_INSTR[3]; a_in_imm_src = V_SRC[3]; a_in_tag = 32'h33;
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_imm !== 32'h12345000 || a_out_tag !== 32'h33)
            begin errors++; $display("FAIL rm_first: valid=%b imm=%h tag=%h, required 1 12345000 33", a_out_valid, a_out_imm, a_out_tag); end
        else $display("reset-mid first: imm=%h tag=%h", a_out_imm, a_out_tag);
        a_in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_accept_drain();
        a_out_ready = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b1; a_in_instr = V_INSTR[0]; a_in_imm_src = V_SRC[0]; a_in_tag = 32'h40;
        @(negedge clk);
        checks++;
        if (a_out_imm !== 32'hFFFFFFFF || a_out_valid !== 1'b1)
            begin errors++; $display("FAIL ad_one: valid=%b imm=%h, required 1 ffffffff", a_out_valid, a_out_imm); end
        a_in_instr = V_INSTR[1]; a_in_imm_src = V_SRC[1]; a_in_tag = 32'h41;
        @(posedge clk);
        #1;
        checks++;
        if (a_out_valid !== 1'b1 || a_out_imm !== 32'h6 || a_out_tag !== 32'h41 || a_in_ready !== 1'b1)
            begin errors++; $display("FAIL ad_update: valid=%b imm=%h tag=%h in_ready=%b, required 1 00000006 41 1", a_out_valid, a_out_imm, a_out_tag, a_in_ready); end
        else $display("accept+drain: imm=%h tag=%h", a_out_imm, a_out_tag);
        @(negedge clk);
        a_in_valid = 1'b0;
    endtask

    task automatic test_idle_instr();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_in_instr = 32'hDEAD0000 + i;
            a_in_imm_src = IMM_U;
        end
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0 || a_out_imm !== 32'h6)
            begin errors++; $display("FAIL idle: valid=%b imm=%h, required 0 00000006", a_out_valid, a_out_imm); end
        else $display("idle instr changes ignored");
    endtask

    initial begin
        test_reset();
        test_manual_b2b();
        test_xlen();
        test_auto();
        test_back_pressure();
        test_reset_mid();
        test_accept_drain();
        test_idle_instr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
